// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
//
// Registered immediate-generation stage between fetch/decode and register
// read. Each accepted instruction is decoded combinationally, then held in a
// one-entry output register backed by one skid entry. This keeps throughput at
// one instruction per cycle while in_ready_o stays a pure flop output.
//
// Configuration macro:
//   IMM_GEN_ZICSR_EN - when defined, opcode 1110011 decodes as CSR_UIMM for
//                      funct3 101/110/111 and as I format otherwise. When it
//                      is undefined, that opcode is reported illegal and no
//                      CSR decode logic exists.
//
// Parameters:
//   XLEN        datapath width, 32 or 64
//
// Ports:
//   clk          core clock, rising edge
//   reset        asynchronous active-high reset
//   flush_i      synchronous kill of all buffered entries (beats accept)
//   in_valid_i   upstream instruction valid
//   in_ready_o   stage can accept (registered, equals !skid_full)
//   instr_i      raw 32-bit instruction
//   out_valid_o  result valid
//   out_ready_i  downstream accepts result
//   instr_o      instruction aligned with imm_o
//   imm_o        extended immediate (XLEN bits)
//   imm_type_o   0=I 1=S 2=B 3=U 4=J 5=SHAMT 6=CSR_UIMM 7=NONE
//   illegal_o    opcode not recognised (or CSR with the feature disabled)
// -----------------------------------------------------------------------------
module imm_gen_pipe #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush_i,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [31:0]     instr_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [31:0]     instr_o,
  output logic [XLEN-1:0] imm_o,
  output logic [2:0]      imm_type_o,
  output logic            illegal_o
);

  // Derived from XLEN; deliberately not a parameter so it cannot be overridden.
  localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

  localparam logic [2:0] T_I     = 3'd0;
  localparam logic [2:0] T_S     = 3'd1;
  localparam logic [2:0] T_B     = 3'd2;
  localparam logic [2:0] T_U     = 3'd3;
  localparam logic [2:0] T_J     = 3'd4;
  localparam logic [2:0] T_SHAMT = 3'd5;
`ifdef IMM_GEN_ZICSR_EN
  localparam logic [2:0] T_CSR   = 3'd6;
`endif
  localparam logic [2:0] T_NONE  = 3'd7;

  // ---------------------------------------------------------------------------
  // Combinational decode of the incoming instruction
  // ---------------------------------------------------------------------------
  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] dec_imm;
  logic [2:0]      dec_type;
  logic            dec_ill;

  assign opcode = instr_i[6:0];
  assign funct3 = instr_i[14:12];

  // Sized casts of $signed operands sign-extend; unsigned operands zero-extend.
  always_comb begin
    dec_imm  = '0;
    dec_type = T_NONE;
    dec_ill  = 1'b0;
    case (opcode)
      7'b0000011, 7'b1100111: begin
        dec_imm  = XLEN'($signed(instr_i[31:20]));
        dec_type = T_I;
      end
      7'b0010011: begin
        if (funct3 == 3'b001 || funct3 == 3'b101) begin
          dec_imm  = XLEN'(instr_i[20 +: SHAMT_W]);
          dec_type = T_SHAMT;
        end else begin
          dec_imm  = XLEN'($signed(instr_i[31:20]));
          dec_type = T_I;
        end
      end
      7'b0011011: begin
        // Word-sized ops only exist on RV64; shift amount is always 5 bits.
        if (XLEN == 64) begin
          if (funct3 == 3'b001 || funct3 == 3'b101) begin
            dec_imm  = XLEN'(instr_i[24:20]);
            dec_type = T_SHAMT;
          end else begin
            dec_imm  = XLEN'($signed(instr_i[31:20]));
            dec_type = T_I;
          end
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0100011: begin
        dec_imm  = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
        dec_type = T_S;
      end
      7'b1100011: begin
        dec_imm  = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                  instr_i[11:8], 1'b0}));
        dec_type = T_B;
      end
      7'b1101111: begin
        dec_imm  = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                  instr_i[30:21], 1'b0}));
        dec_type = T_J;
      end
      7'b0110111, 7'b0010111: begin
        dec_imm  = XLEN'($signed({instr_i[31:12], 12'b0}));
        dec_type = T_U;
      end
      7'b0110011: begin
        dec_type = T_NONE;
      end
      7'b0111011: begin
        dec_ill = (XLEN != 64);
      end
`ifdef IMM_GEN_ZICSR_EN
      7'b1110011: begin
        if (funct3[2] && funct3 != 3'b100) begin
          dec_imm  = XLEN'(instr_i[19:15]);
          dec_type = T_CSR;
        end else begin
          dec_imm  = XLEN'($signed(instr_i[31:20]));
          dec_type = T_I;
        end
      end
`endif
      default: begin
        dec_ill = 1'b1;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output register + skid entry
  // ---------------------------------------------------------------------------
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_instr_q, out_instr_d;
  logic [XLEN-1:0] out_imm_q,   out_imm_d;
  logic [2:0]      out_type_q,  out_type_d;
  logic            out_ill_q,   out_ill_d;

  logic            skid_valid_q, skid_valid_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [XLEN-1:0] skid_imm_q,   skid_imm_d;
  logic [2:0]      skid_type_q,  skid_type_d;
  logic            skid_ill_q,   skid_ill_d;

  logic accept;
  logic drain;

  // Ready depends only on the skid flop, never on out_ready_i.
  assign in_ready_o = !skid_valid_q;
  assign accept     = in_valid_i && !skid_valid_q;
  assign drain      = out_valid_q && out_ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_instr_d  = out_instr_q;
    out_imm_d    = out_imm_q;
    out_type_d   = out_type_q;
    out_ill_d    = out_ill_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    skid_imm_d   = skid_imm_q;
    skid_type_d  = skid_type_q;
    skid_ill_d   = skid_ill_q;

    if (flush_i) begin
      // Only the valid bits clear; payload registers keep their data.
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (skid_valid_q) begin
      // Skid full means nothing is accepted; on drain the skid moves forward.
      if (drain) begin
        out_instr_d  = skid_instr_q;
        out_imm_d    = skid_imm_q;
        out_type_d   = skid_type_q;
        out_ill_d    = skid_ill_q;
        skid_valid_d = 1'b0;
      end
    end else if (accept && (!out_valid_q || drain)) begin
      out_valid_d = 1'b1;
      out_instr_d = instr_i;
      out_imm_d   = dec_imm;
      out_type_d  = dec_type;
      out_ill_d   = dec_ill;
    end else if (accept) begin
      // Output stalled: park the new entry in the skid.
      skid_valid_d = 1'b1;
      skid_instr_d = instr_i;
      skid_imm_d   = dec_imm;
      skid_type_d  = dec_type;
      skid_ill_d   = dec_ill;
    end else if (drain) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_instr_q  <= '0;
      out_imm_q    <= '0;
      out_type_q   <= T_NONE;
      out_ill_q    <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
      skid_imm_q   <= '0;
      skid_type_q  <= T_NONE;
      skid_ill_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_instr_q  <= out_instr_d;
      out_imm_q    <= out_imm_d;
      out_type_q   <= out_type_d;
      out_ill_q    <= out_ill_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
      skid_imm_q   <= skid_imm_d;
      skid_type_q  <= skid_type_d;
      skid_ill_q   <= skid_ill_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign instr_o     = out_instr_q;
  assign imm_o       = out_imm_q;
  assign imm_type_o  = out_type_q;
  assign illegal_o   = out_ill_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Testbench for imm_gen_pipe: one XLEN=32 and one XLEN=64 instance share the
// same stimulus; each has its own expected-result queue and monitor.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] instr;
  logic        out_ready;

  logic        in_ready32, out_valid32, ill32;
  logic [31:0] instr_o32, imm_o32;
  logic [2:0]  type32;

  logic        in_ready64, out_valid64, ill64;
  logic [31:0] instr_o64;
  logic [63:0] imm_o64;
  logic [2:0]  type64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32)) dut32 (
    .clk(clk), .reset(reset), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready32), .instr_i(instr),
    .out_valid_o(out_valid32), .out_ready_i(out_ready),
    .instr_o(instr_o32), .imm_o(imm_o32), .imm_type_o(type32), .illegal_o(ill32)
  );

  imm_gen_pipe #(.XLEN(64)) dut64 (
    .clk(clk), .reset(reset), .flush_i(flush),
    .in_valid_i(in_valid), .in_ready_o(in_ready64), .instr_i(instr),
    .out_valid_o(out_valid64), .out_ready_i(out_ready),
    .instr_o(instr_o64), .imm_o(imm_o64), .imm_type_o(type64), .illegal_o(ill64)
  );

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  typedef struct {
    logic [31:0] instr;
    logic [63:0] imm32;
    logic [2:0]  t32;
    logic        i32;
    logic [63:0] imm64;
    logic [2:0]  t64;
    logic        i64;
  } vec_t;

  exp_t q32[$];
  exp_t q64[$];
  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic add_vec(input logic [31:0] ins,
                         input logic [63:0] m32, input logic [2:0] t32, input logic i32,
                         input logic [63:0] m64, input logic [2:0] t64, input logic i64);
    vec_t v;
    v.instr = ins; v.imm32 = m32; v.t32 = t32; v.i32 = i32;
    v.imm64 = m64; v.t64 = t64; v.i64 = i64;
    vecs.push_back(v);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input vec_t v, input bit expect_it);
    bit done = 0;
    in_valid = 1'b1;
    instr    = v.instr;
    for (int n = 0; n < 50 && !done; n++) begin
      @(negedge clk);
      if (in_ready32) begin
        done = 1;
        if (expect_it) begin
          q32.push_back('{v.instr, v.imm32, v.t32, v.i32});
          q64.push_back('{v.instr, v.imm64, v.t64, v.i64});
        end
      end
      @(posedge clk); #1;
    end
    if (!done) chk("send_timeout", {63'b0, in_ready32}, 64'd1);
    in_valid = 1'b0;
  endtask

  // Monitors: compare whenever a transfer happens at the coming edge.
  always @(negedge clk) begin
    if (!reset && out_valid32 && out_ready) begin
      if (q32.size() == 0) begin
        chk("out32_unexpected", {32'b0, instr_o32}, 64'd0);
      end else begin
        exp_t e;
        e = q32.pop_front();
        $display("OUT32 instr=%h imm=%h type=%0d ill=%0b", instr_o32, imm_o32, type32, ill32);
        chk("imm32",   {32'b0, imm_o32}, e.imm);
        chk("type32",  {61'b0, type32},  {61'b0, e.typ});
        chk("ill32",   {63'b0, ill32},   {63'b0, e.ill});
        chk("instr32", {32'b0, instr_o32}, {32'b0, e.instr});
      end
    end
    if (!reset && out_valid64 && out_ready) begin
      if (q64.size() == 0) begin
        chk("out64_unexpected", {32'b0, instr_o64}, 64'd0);
      end else begin
        exp_t e;
        e = q64.pop_front();
        $display("OUT64 instr=%h imm=%h type=%0d ill=%0b", instr_o64, imm_o64, type64, ill64);
        chk("imm64",   imm_o64,          e.imm);
        chk("type64",  {61'b0, type64},  {61'b0, e.typ});
        chk("ill64",   {63'b0, ill64},   {63'b0, e.ill});
        chk("instr64", {32'b0, instr_o64}, {32'b0, e.instr});
      end
    end
  end

  initial begin
    vec_t va, vb, vc;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = '0; out_ready = 1'b0;

    //        instr         imm32                  t  i   imm64                  t  i
    add_vec(32'hFFF00093, 64'h00000000_FFFFFFFF, 0, 0, 64'hFFFFFFFF_FFFFFFFF, 0, 0); // addi -1
    add_vec(32'h01F09093, 64'h1F,                5, 0, 64'h1F,                5, 0); // slli 31
    add_vec(32'hFE000EE3, 64'h00000000_FFFFFFFC, 2, 0, 64'hFFFFFFFF_FFFFFFFC, 2, 0); // beq -4
    add_vec(32'h800000B7, 64'h00000000_80000000, 3, 0, 64'hFFFFFFFF_80000000, 3, 0); // lui
    add_vec(32'h03F09093, 64'h1F,                5, 0, 64'h3F,                5, 0); // slli 63
    add_vec(32'h4050D093, 64'h05,                5, 0, 64'h05,                5, 0); // srai 5
    add_vec(32'hFE112E23, 64'h00000000_FFFFFFFC, 1, 0, 64'hFFFFFFFF_FFFFFFFC, 1, 0); // sw -4
    add_vec(32'h0080006F, 64'h08,                4, 0, 64'h08,                4, 0); // jal 8
    add_vec(32'h00001097, 64'h1000,              3, 0, 64'h1000,              3, 0); // auipc
    add_vec(32'hFFC12083, 64'h00000000_FFFFFFFC, 0, 0, 64'hFFFFFFFF_FFFFFFFC, 0, 0); // lw -4
    add_vec(32'h002081B3, 64'h0,                 7, 0, 64'h0,                 7, 0); // add
    add_vec(32'hFFF0809B, 64'h0,                 7, 1, 64'hFFFFFFFF_FFFFFFFF, 0, 0); // addiw
    add_vec(32'h0000007F, 64'h0,                 7, 1, 64'h0,                 7, 1); // bad opcode
`ifdef IMM_GEN_ZICSR_EN
    add_vec(32'h34029073, 64'h340,               0, 0, 64'h340,               0, 0); // csrrw
    add_vec(32'h3402D073, 64'h5,                 6, 0, 64'h5,                 6, 0); // csrrwi 5
`else
    add_vec(32'h34029073, 64'h0,                 7, 1, 64'h0,                 7, 1);
    add_vec(32'h3402D073, 64'h0,                 7, 1, 64'h0,                 7, 1);
`endif

    va = vecs[0]; va.instr = 32'h00500093; va.imm32 = 64'd5;  va.imm64 = 64'd5;  va.t32 = 0; va.t64 = 0;
    vb = vecs[0]; vb.instr = 32'h00A00113; vb.imm32 = 64'd10; vb.imm64 = 64'd10; vb.t32 = 0; vb.t64 = 0;
    vc = va;      vc.instr = 32'h00700093; vc.imm32 = 64'd7;  vc.imm64 = 64'd7;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid32", {63'b0, out_valid32}, 64'd0);
    chk("rst_imm32",   {32'b0, imm_o32},     64'd0);
    chk("rst_instr32", {32'b0, instr_o32},   64'd0);
    chk("rst_type32",  {61'b0, type32},      64'd7);
    chk("rst_ill32",   {63'b0, ill32},       64'd0);
    chk("rst_imm64",   imm_o64,              64'd0);
    chk("rst_type64",  {61'b0, type64},      64'd7);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready32", {63'b0, in_ready32}, 64'd1);
    chk("rst_ready64", {63'b0, in_ready64}, 64'd1);
    @(posedge clk); #1;

    // Back-to-back stream with the output always ready
    out_ready = 1'b1;
    foreach (vecs[i]) send(vecs[i], 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: A to output, B to skid, ready drops
    out_ready = 1'b0;
    send(va, 1'b1);
    send(vb, 1'b1);
    @(negedge clk);
    chk("bp_ready_low",  {63'b0, in_ready32},  64'd0);
    chk("bp_valid",      {63'b0, out_valid32}, 64'd1);
    repeat (2) @(negedge clk);
    chk("bp_hold_imm",   {32'b0, imm_o32},     64'd5);
    chk("bp_hold_instr", {32'b0, instr_o32},   64'h00500093);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_still_low", {63'b0, in_ready32}, 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_ready_up",  {63'b0, in_ready32},  64'd1);
    chk("bp_b_next",    {32'b0, imm_o32},     64'd10);
    chk("bp_b_valid",   {63'b0, out_valid32}, 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_empty", {63'b0, out_valid32}, 64'd0);
    @(posedge clk); #1;

    // Flush with both entries full and an input offered
    out_ready = 1'b0;
    send(va, 1'b0);
    send(vb, 1'b0);
    in_valid = 1'b1; instr = vc.instr; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("fl_valid",    {63'b0, out_valid32}, 64'd0);
    chk("fl_ready",    {63'b0, in_ready32},  64'd1);
    chk("fl_keep_imm", {32'b0, imm_o32},     64'd5);

    // Flush beats accept while the skid is still empty
    @(posedge clk); #1;
    send(va, 1'b0);
    in_valid = 1'b1; instr = vc.instr; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk("fl2_valid", {63'b0, out_valid32}, 64'd0);
    chk("fl2_ready", {63'b0, in_ready32},  64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    send(vecs[2], 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset in the middle of a transfer
    out_ready = 1'b0;
    send(va, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", {63'b0, out_valid32}, 64'd0);
    chk("arst_imm",   {32'b0, imm_o32},     64'd0);
    chk("arst_type",  {61'b0, type32},      64'd7);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    chk("q32_drained", 64'(q32.size()), 64'd0);
    chk("q64_drained", 64'(q64.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Registered, parametrised immediate-generation stage for the pipelined core. Sits between fetch/decode and the register-read stage.
- Accepts one instruction per cycle over a valid/ready handshake and extracts and sign/zero-extends the immediate to XLEN.
- Reports the immediate format and an illegal-opcode flag.
- Has a 2-entry skid buffer, so full throughput is kept under downstream backpressure and pipeline flushes are supported.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Controls extension width and shift-amount width.
- SHAMT_W, (XLEN==64 ? 6 : 5), derived shift-amount field width. Not to be overridden.

Ports:
- clk  input  1  core clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- flush_i  input  1  synchronous kill of all buffered entries.
- in_valid_i  input  1  upstream instruction valid.
- in_ready_o  output  1  stage can accept an instruction.
- instr_i  input  32  raw instruction.
- out_valid_o  output  1  immediate result valid.
- out_ready_i  input  1  downstream accepts the result.
- instr_o  output  32  instruction passed through, aligned with imm_o.
- imm_o  output  XLEN  extended immediate.
- imm_type_o  output  3  format code: 0=I, 1=S, 2=B, 3=U, 4=J, 5=SHAMT, 6=CSR_UIMM, 7=NONE.
- illegal_o  output  1  opcode not recognised, or CSR format with the feature disabled.

Behaviour:
- Reset (asynchronous, active-high):
  - out_valid_o=0, in_ready_o=1 once reset deasserts.
  - imm_o=0, instr_o=0, imm_type_o=7, illegal_o=0.
  - Skid buffer empty.
- Decode, combinational on instr_i[6:0], captured on accept:
  - 0000011, 1100111: I format, sext(instr[31:20]).
  - 0010011, funct3 001/101: SHAMT format, zext(instr[20+SHAMT_W-1:20]).
  - 0010011, other funct3: I format.
  - 0011011 (XLEN=64 only), funct3 001/101: SHAMT format, 5-bit zext(instr[24:20]); other funct3: I format. When XLEN=32 this opcode is illegal.
  - 0100011: S format, sext({instr[31:25], instr[11:7]}).
  - 1100011: B format, sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 1101111: J format, sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110111, 0010111: U format, sext({instr[31:12], 12'b0}). Upper bits are sign-extended when XLEN=64.
  - 0110011, 0111011 (the latter only when XLEN=64): R-type, imm=0, type 7, legal.
  - 1110011: see Optional Feature.
  - Any other opcode: imm=0, type 7, illegal_o=1.
- Handshake:
  - Transfer in when in_valid_i && in_ready_o; transfer out when out_valid_o && out_ready_i.
  - Latency is exactly 1 cycle from an accepted input to out_valid_o when the output register is empty or draining.
  - in_ready_o = !skid_full, registered with no combinational path from out_ready_i.
  - Output register stalled (out_valid_o && !out_ready_i) and an input is accepted: the input goes to the skid entry and in_ready_o drops next cycle.
  - Output drains while the skid entry is full: the skid entry moves to the output and in_ready_o rises next cycle.
  - Accepting while draining with an empty skid: the new entry goes directly to the output. No bubble; back-to-back throughput is 1 per cycle.
  - Outputs are held stable while out_valid_o && !out_ready_i.
- Flush:
  - flush_i=1 at a clock edge empties the output and skid entries: out_valid_o=0, in_ready_o=1 next cycle.
  - Any input offered in the same cycle is discarded; flush has priority over accept.
  - imm_o and instr_o keep their data; only the valid bits clear.
- Ordering: strict FIFO, never reordered or duplicated.
- Reset asserted mid-transfer: all entries are dropped immediately, asynchronously.

Optional Feature:
- Macro IMM_GEN_ZICSR_EN.
- Defined: opcode 1110011 with funct3 101/110/111 gives CSR_UIMM format (type 6), zext(instr[19:15]), legal. Other funct3 values (ECALL/EBREAK/CSRRW/CSRRS/CSRRC) give I format: sext(instr[31:20]) with type 0, legal.
- Not defined: opcode 1110011 gives imm=0, type 7, illegal_o=1. No CSR logic is synthesised.

Test Plan:
- XLEN=32, instr 0xFFF00093 (addi x1,x0,-1), out_ready_i=1 → one cycle later imm_o=0xFFFFFFFF, type 0, illegal 0.
- XLEN=32, 0x01F09093 (slli x1,x1,31) → imm_o=0x0000001F, type 5. Then 0xFE000EE3 (beq -4) → imm_o=0xFFFFFFFC, type 2.
- XLEN=64, 0x800000B7 (lui x1,0x80000) → imm_o=0xFFFFFFFF80000000, type 3. Then 0x03F09093 (slli 63) → imm_o=0x3F.
- Backpressure: out_ready_i=0, issue A=0x00500093 then B=0x00A00113 → in_ready_o=0 after B. Release out_ready_i → A (imm 5) then B (imm 10) on consecutive cycles, in_ready_o=1 after A leaves.
- Flush with both entries full plus in_valid_i=1 → next cycle out_valid_o=0, in_ready_o=1; the offered instruction never appears.
- 0x34029073 (csrrw) and 0x3402D073 (csrrwi uimm=5): macro defined → type 0 imm 0x340, then type 6 imm 5. Macro undefined → illegal_o=1 for both.
